// File: rtl/dmac_req_scheduler.sv
// Request sequencer for the two-channel DMAC: arbitrate, wait for config, own the bus, run one channel.
// Optional transfer watchdog in ACTIVE is built when DMAC_WATCHDOG_EN is defined.
module dmac_req_scheduler #(
  parameter int FIXED_PRIO  = 1,
  parameter int WDOG_CYCLES = 4096,
  parameter int WDOG_W      = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] dmac_req,
  input  logic       c_config,
  input  logic       irq,
  input  logic       hgrant,
  input  logic [1:0] hresp,
  output logic       channel_en_1,
  output logic       channel_en_2,
  output logic       con_en,
  output logic       con_sel,
  output logic       hbusreq,
  output logic [1:0] req_ack,
  output logic       err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_CFG = 3'd1,
    BUS_REQ  = 3'd2,
    ARM      = 3'd3,
    ACTIVE   = 3'd4,
    DONE     = 3'd5,
    ABORT    = 3'd6
  } state_t;

  state_t state_r;
  state_t next_state_s;
  logic   sel_r;
  logic   next_sel_s;
  logic   last_served_r;
  logic   winner_s;
  logic   hresp_err_s;
  logic   wdog_trip_s;
  logic   in_xfer_s;

  assign hresp_err_s = (hresp == 2'b01);

`ifdef DMAC_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_r;

  // ACTIVE-cycle counter: zero on the first ACTIVE cycle, saturating so it never wraps back to a safe value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_r <= '0;
    end else if (state_r == ARM) begin
      wdog_r <= '0;
    end else if ((state_r == ACTIVE) && (wdog_r != '1)) begin
      wdog_r <= wdog_r + WDOG_W'(1);
    end
  end

  assign wdog_trip_s = (state_r == ACTIVE) && (wdog_r >= WDOG_W'(WDOG_CYCLES - 1));
`else
  assign wdog_trip_s = 1'b0;
`endif

  // Arbitration winner among the pending requests (only consumed in IDLE)
  always_comb begin
    if (dmac_req == 2'b11) begin
      if (FIXED_PRIO != 32'sd0) begin
        winner_s = 1'b0;
      end else begin
        winner_s = ~last_served_r;
      end
    end else begin
      winner_s = dmac_req[1];
    end
  end

  // Next-state decode; an ERROR response outranks irq, irq outranks the watchdog
  always_comb begin
    next_state_s = state_r;
    next_sel_s   = sel_r;
    case (state_r)
      IDLE: begin
        if (dmac_req != 2'b00) begin
          next_state_s = WAIT_CFG;
          next_sel_s   = winner_s;
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT_CFG: begin
        if (!dmac_req[sel_r]) begin
          next_state_s = IDLE;
        end else if (c_config) begin
          next_state_s = BUS_REQ;
        end else begin
          next_state_s = WAIT_CFG;
        end
      end
      BUS_REQ: begin
        if (!dmac_req[sel_r]) begin
          next_state_s = IDLE;
        end else if (hgrant) begin
          next_state_s = ARM;
        end else begin
          next_state_s = BUS_REQ;
        end
      end
      ARM: begin
        next_state_s = ACTIVE;
      end
      ACTIVE: begin
        if (hresp_err_s) begin
          next_state_s = ABORT;
        end else if (irq) begin
          next_state_s = DONE;
        end else if (wdog_trip_s) begin
          next_state_s = ABORT;
        end else begin
          next_state_s = ACTIVE;
        end
      end
      DONE:    next_state_s = IDLE;
      ABORT:   next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, selected channel and round-robin history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      sel_r         <= 1'b0;
      last_served_r <= 1'b1;
    end else begin
      state_r <= next_state_s;
      sel_r   <= next_sel_s;
      if ((state_r == DONE) || (state_r == ABORT)) begin
        last_served_r <= sel_r;
      end
    end
  end

  assign in_xfer_s = (next_state_s == ARM) || (next_state_s == ACTIVE);

  // Outputs registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      channel_en_1 <= 1'b0;
      channel_en_2 <= 1'b0;
      con_en       <= 1'b0;
      con_sel      <= 1'b0;
      hbusreq      <= 1'b0;
      req_ack      <= 2'b00;
      err          <= 1'b0;
      busy         <= 1'b0;
    end else begin
      channel_en_1 <= in_xfer_s & ~next_sel_s;
      channel_en_2 <= in_xfer_s & next_sel_s;
      con_en       <= (next_state_s == ARM);
      con_sel      <= (next_state_s == ARM) ? next_sel_s : con_sel;
      hbusreq      <= in_xfer_s || (next_state_s == BUS_REQ);
      req_ack      <= (next_state_s == DONE) ? {sel_r, ~sel_r} : 2'b00;
      err          <= (next_state_s == ABORT);
      busy         <= (next_state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_dmac_req_scheduler.sv
// Bench for dmac_req_scheduler: a fixed-priority and a round-robin instance share stimulus and are
// checked every cycle against a procedural transaction model, plus hand-computed spot checks.
module tb_dmac_req_scheduler;
  localparam int TB_WDOG = 16;

  logic       clk;
  logic       rst;
  logic [1:0] dmac_req;
  logic       c_config;
  logic       irq;
  logic       hgrant;
  logic [1:0] hresp;

  logic [1:0] en1, en2, con_en, con_sel, hbusreq, err, busy;
  logic [1:0] ack [2];

  int vectors;
  int miscompares;

  // Expected outputs, index 0 = fixed priority instance, 1 = round-robin instance
  logic [1:0] m_en  [2];
  logic [1:0] m_ack [2];
  logic       m_con_en [2];
  logic       m_con_sel [2];
  logic       m_hbusreq [2];
  logic       m_err [2];
  logic       m_busy [2];
  int         m_last [2];

  dmac_req_scheduler #(.FIXED_PRIO(1), .WDOG_CYCLES(TB_WDOG), .WDOG_W(5)) u_fix (
    .clk(clk), .rst(rst), .dmac_req(dmac_req), .c_config(c_config), .irq(irq),
    .hgrant(hgrant), .hresp(hresp), .channel_en_1(en1[0]), .channel_en_2(en2[0]),
    .con_en(con_en[0]), .con_sel(con_sel[0]), .hbusreq(hbusreq[0]), .req_ack(ack[0]),
    .err(err[0]), .busy(busy[0]));

  dmac_req_scheduler #(.FIXED_PRIO(0), .WDOG_CYCLES(TB_WDOG), .WDOG_W(5)) u_rr (
    .clk(clk), .rst(rst), .dmac_req(dmac_req), .c_config(c_config), .irq(irq),
    .hgrant(hgrant), .hresp(hresp), .channel_en_1(en1[1]), .channel_en_2(en2[1]),
    .con_en(con_en[1]), .con_sel(con_sel[1]), .hbusreq(hbusreq[1]), .req_ack(ack[1]),
    .err(err[1]), .busy(busy[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: one transfer walked as a sequential script ----------------
  task automatic m_zero(input int k);
    m_en[k] = 2'b00; m_ack[k] = 2'b00; m_con_en[k] = 1'b0; m_con_sel[k] = 1'b0;
    m_hbusreq[k] = 1'b0; m_err[k] = 1'b0; m_busy[k] = 1'b0; m_last[k] = 1;
  endtask

  task automatic tick(input int k, output bit r);
    @(posedge clk or posedge rst);
    r = rst;
    if (r) m_zero(k);
  endtask

  task automatic serve(input int k, input int w);
    bit r;
    bit fail;
    int cycles;
    fail = 1'b0;
    m_busy[k] = 1'b1;
    forever begin
      tick(k, r);
      if (r) return;
      if (!dmac_req[w]) begin m_busy[k] = 1'b0; return; end
      if (c_config) break;
    end
    m_hbusreq[k] = 1'b1;
    forever begin
      tick(k, r);
      if (r) return;
      if (!dmac_req[w]) begin m_busy[k] = 1'b0; m_hbusreq[k] = 1'b0; return; end
      if (hgrant) break;
    end
    m_con_en[k] = 1'b1; m_con_sel[k] = (w == 1); m_en[k][w] = 1'b1;
    tick(k, r);
    if (r) return;
    m_con_en[k] = 1'b0;
    cycles = 0;
    forever begin
      tick(k, r);
      if (r) return;
      cycles++;
      if (hresp == 2'b01) begin fail = 1'b1; break; end
      if (irq) break;
`ifdef DMAC_WATCHDOG_EN
      if (cycles >= TB_WDOG) begin fail = 1'b1; break; end
`endif
    end
    m_en[k] = 2'b00; m_hbusreq[k] = 1'b0;
    if (fail) m_err[k] = 1'b1;
    else m_ack[k][w] = 1'b1;
    m_last[k] = w;
    tick(k, r);
    if (r) return;
    m_err[k] = 1'b0; m_ack[k] = 2'b00; m_busy[k] = 1'b0;
  endtask

  task automatic model_run(input int k);
    bit r;
    int w;
    m_zero(k);
    forever begin
      tick(k, r);
      if (!r && dmac_req != 2'b00) begin
        if (dmac_req == 2'b01) w = 0;
        else if (dmac_req == 2'b10) w = 1;
        else if (k == 0) w = 0;
        else w = (m_last[k] == 0) ? 1 : 0;
        serve(k, w);
      end
    end
  endtask

  initial model_run(0);
  initial model_run(1);

  // ---------------- checking ----------------
  function automatic logic [8:0] dut_vec(input int k);
    return {en1[k], en2[k], con_en[k], con_sel[k], hbusreq[k], ack[k], err[k], busy[k]};
  endfunction

  function automatic logic [8:0] exp_vec(input int k);
    return {m_en[k][0], m_en[k][1], m_con_en[k], m_con_sel[k], m_hbusreq[k], m_ack[k], m_err[k], m_busy[k]};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (dut_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL cycle_cmp inst%0d t=%0t {en1,en2,con_en,con_sel,hbusreq,ack,err,busy} got=%b want=%b",
                   k, $time, dut_vec(k), exp_vec(k));
        end
      end
    end
  end

  task automatic chk(input string name, input logic [1:0] got, input logic [1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, got, want);
    end
  endtask

  task automatic nc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; dmac_req = 2'b00; c_config = 1'b0; irq = 1'b0; hgrant = 1'b0; hresp = 2'b00;
    nc(2);
    chk("reset_busy", busy, 2'b00);
    chk("reset_hbusreq", hbusreq, 2'b00);
    rst = 1'b0;
    nc(2);

    // simultaneous requests, three transfers: fixed 1,1,1 / round-robin 1,2,1
    dmac_req = 2'b11; c_config = 1'b1; hgrant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nc(3);
      chk("tie_sel_fix", {1'b0, con_sel[0]}, 2'b00);
      chk("tie_sel_rr", {1'b0, con_sel[1]}, (i == 1) ? 2'b01 : 2'b00);
      chk("tie_en_rr", {en2[1], en1[1]}, (i == 1) ? 2'b10 : 2'b01);
      nc(1); irq = 1'b1;
      nc(1);
      chk("tie_ack_fix", ack[0], 2'b01);
      chk("tie_ack_rr", ack[1], (i == 1) ? 2'b10 : 2'b01);
      irq = 1'b0;
      nc(1);
      chk("tie_idle", busy, 2'b00);
    end
    dmac_req = 2'b00;
    nc(2);

    // single request, minimum latency
    dmac_req = 2'b01;
    nc(1); chk("single_busy", busy, 2'b11);
    nc(2);
    chk("single_con_en", con_en, 2'b11);
    chk("single_con_sel", con_sel, 2'b00);
    chk("single_en1", en1, 2'b11);
    nc(3); chk("single_en1_hold", en1, 2'b11);
    irq = 1'b1; dmac_req = 2'b00;
    nc(1);
    chk("single_ack", ack[0], 2'b01);
    chk("single_en_off", en1, 2'b00);
    irq = 1'b0;
    nc(1); chk("single_busy_off", busy, 2'b00);

    // config gating, stray irq, cancel before grant
    c_config = 1'b0; hgrant = 1'b0; dmac_req = 2'b10;
    nc(10); irq = 1'b1; nc(1); irq = 1'b0; nc(9);
    chk("cfg_gated_hbusreq", hbusreq, 2'b00);
    chk("cfg_gated_busy", busy, 2'b11);
    c_config = 1'b1;
    nc(1); chk("cfg_hbusreq_up", hbusreq, 2'b11);
    nc(2); dmac_req = 2'b00;
    nc(1);
    chk("cancel_busy", busy, 2'b00);
    chk("cancel_hbusreq", hbusreq, 2'b00);
    chk("cancel_ack", ack[0] | ack[1], 2'b00);
    hgrant = 1'b1;
    nc(2);

    // second request during channel 2 ACTIVE
    dmac_req = 2'b10;
    nc(3);
    chk("mid_sel2", con_sel, 2'b11);
    chk("mid_en2", en2, 2'b11);
    nc(1); dmac_req = 2'b11;
    nc(3);
    chk("mid_en2_hold", en2, 2'b11);
    chk("mid_en1_low", en1, 2'b00);
    irq = 1'b1; dmac_req = 2'b01;
    nc(1); chk("mid_ack2", ack[0] & ack[1], 2'b10);
    irq = 1'b0;
    nc(1); chk("mid_gap", busy, 2'b00);
    nc(3);
    chk("mid_sel1", con_sel, 2'b00);
    chk("mid_en1", en1, 2'b11);
    chk("mid_en2_off", en2, 2'b00);

    // ERROR response together with irq: abort wins
    nc(1); hresp = 2'b01; irq = 1'b1;
    nc(1);
    chk("err_pulse", err, 2'b11);
    chk("err_no_ack", ack[0] | ack[1], 2'b00);
    chk("err_en_off", en1, 2'b00);
    hresp = 2'b00; irq = 1'b0; dmac_req = 2'b00;
    nc(1);
    chk("err_clear", err, 2'b00);
    chk("err_idle", busy, 2'b00);

    // asynchronous reset in ACTIVE, then round-robin history restarts
    dmac_req = 2'b01;
    nc(5);
    #2 rst = 1'b1;
    #1;
    chk("rst_en1", en1, 2'b00);
    chk("rst_hbusreq", hbusreq, 2'b00);
    chk("rst_busy", busy, 2'b00);
    nc(1); rst = 1'b0; dmac_req = 2'b11;
    nc(3); chk("rst_rr_first", {1'b0, con_sel[1]}, 2'b00);
    nc(1); irq = 1'b1; dmac_req = 2'b00;
    nc(1); chk("rst_rr_ack", ack[1], 2'b01);
    irq = 1'b0;
    nc(2);

`ifdef DMAC_WATCHDOG_EN
    // watchdog: no irq for TB_WDOG ACTIVE cycles, then irq at cycle 10
    dmac_req = 2'b01;
    nc(3); dmac_req = 2'b00;
    nc(TB_WDOG); chk("wdog_not_yet", err, 2'b00);
    nc(1);
    chk("wdog_err", err, 2'b11);
    chk("wdog_no_ack", ack[0] | ack[1], 2'b00);
    nc(2);
    dmac_req = 2'b01;
    nc(3); dmac_req = 2'b00;
    nc(10); irq = 1'b1;
    nc(1);
    chk("wdog_irq_ack", ack[0], 2'b01);
    chk("wdog_irq_no_err", err, 2'b00);
    irq = 1'b0;
    nc(2);
`endif

    nc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
